// File: rtl/io_pkg.sv
// Shared definitions for the memory-mapped IO buffer: region bases,
// region enumeration and the byte-lane merge helper.
package io_pkg;

    localparam logic [19:0] BASE_LEDR  = 20'h10000;
    localparam logic [19:0] BASE_LEDG  = 20'h10001;
    localparam logic [19:0] BASE_HEXLO = 20'h10002;
    localparam logic [19:0] BASE_HEXHI = 20'h10003;
    localparam logic [19:0] BASE_LCD   = 20'h10004;
    localparam logic [19:0] BASE_SW    = 20'h10010;

    // Seven-segment lanes only carry bits [6:0]; bit 7 of every lane is dropped.
    localparam logic [31:0] HEX_LANE_MASK = 32'h7F7F7F7F;

    typedef enum logic [2:0] {
        REG_LEDR,
        REG_LEDG,
        REG_HEXLO,
        REG_HEXHI,
        REG_LCD,
        REG_SW,
        REG_NONE
    } region_e;

    // Only the upper 20 address bits select a region; each region is one word.
    function automatic region_e decode_region(input logic [31:0] addr);
        region_e r;
        case (addr[31:12])
            BASE_LEDR:  r = REG_LEDR;
            BASE_LEDG:  r = REG_LEDG;
            BASE_HEXLO: r = REG_HEXLO;
            BASE_HEXHI: r = REG_HEXHI;
            BASE_LCD:   r = REG_LCD;
            BASE_SW:    r = REG_SW;
            default:    r = REG_NONE;
        endcase
        return r;
    endfunction

    // Replace only the byte lanes whose enable bit is set.
    function automatic logic [31:0] apply_bmask(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  bmask);
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (bmask[i]) res[8*i +: 8] = new_word[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/io_buffer_sw_sync.sv
// N-flop synchronizer bringing the asynchronous board switches into i_clk.
module sw_sync #(
    parameter int STAGES = 2,
    parameter int WIDTH  = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    logic [WIDTH-1:0] sync_q [STAGES];

    // Shift the switch value through the flop chain; reset clears every stage.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= i_async;
            for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign o_sync = sync_q[STAGES-1];

endmodule

// File: rtl/io_buffer.sv
// Memory-mapped IO buffer: LSU load/store port onto LED, seven-segment,
// LCD and switch registers. Loads respond one cycle after the request.
module io_buffer
    import io_pkg::*;
#(
    parameter int SW_SYNC_STAGES = 2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_bmask,
    input  logic        i_wren,
    input  logic        i_rden,
    output logic [31:0] o_rdata,
    output logic        o_rvalid,
    output logic        o_err,
    input  logic [31:0] i_io_sw,
    output logic [31:0] o_io_ledr,
    output logic [31:0] o_io_ledg,
    output logic [31:0] o_io_lcd,
    output logic [6:0]  o_io_hex0,
    output logic [6:0]  o_io_hex1,
    output logic [6:0]  o_io_hex2,
    output logic [6:0]  o_io_hex3,
    output logic [6:0]  o_io_hex4,
    output logic [6:0]  o_io_hex5,
    output logic [6:0]  o_io_hex6,
    output logic [6:0]  o_io_hex7
);

    logic [31:0] ledr_q,  ledr_d;
    logic [31:0] ledg_q,  ledg_d;
    logic [31:0] hexlo_q, hexlo_d;
    logic [31:0] hexhi_q, hexhi_d;
    logic [31:0] lcd_q,   lcd_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rvalid_q, rvalid_d;
    logic        err_q,   err_d;
    logic [31:0] sw_sync_w;
    logic [31:0] rd_word;
    region_e     region;

    // Offset bits inside a region carry no meaning.
    logic unused_addr;
    assign unused_addr = ^i_addr[11:0];

    sw_sync #(
        .STAGES (SW_SYNC_STAGES),
        .WIDTH  (32)
    ) u_sw_sync (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_async (i_io_sw),
        .o_sync  (sw_sync_w)
    );

    assign region = decode_region(i_addr);

    // Next-state for IO registers, load mux and error flag. Reads use the
    // current register values, so a same-cycle write returns the old word.
    always_comb begin
        ledr_d  = ledr_q;
        ledg_d  = ledg_q;
        hexlo_d = hexlo_q;
        hexhi_d = hexhi_q;
        lcd_d   = lcd_q;
        if (i_wren) begin
            case (region)
                REG_LEDR:  ledr_d  = apply_bmask(ledr_q,  i_wdata, i_bmask);
                REG_LEDG:  ledg_d  = apply_bmask(ledg_q,  i_wdata, i_bmask);
                REG_HEXLO: hexlo_d = apply_bmask(hexlo_q, i_wdata & HEX_LANE_MASK, i_bmask);
                REG_HEXHI: hexhi_d = apply_bmask(hexhi_q, i_wdata & HEX_LANE_MASK, i_bmask);
                REG_LCD:   lcd_d   = apply_bmask(lcd_q,   i_wdata, i_bmask);
                default:   ;
            endcase
        end

        rd_word = '0;
        case (region)
            REG_LEDR:  rd_word = ledr_q;
            REG_LEDG:  rd_word = ledg_q;
            REG_HEXLO: rd_word = hexlo_q;
            REG_HEXHI: rd_word = hexhi_q;
            REG_LCD:   rd_word = lcd_q;
            REG_SW:    rd_word = sw_sync_w;
            default:   rd_word = '0;
        endcase

        rvalid_d = i_rden;
        rdata_d  = i_rden ? rd_word : '0;
        err_d    = (i_rden && (region == REG_NONE)) ||
                   (i_wren && ((region == REG_NONE) || (region == REG_SW)));
    end

    // IO registers and the registered load response.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            ledr_q   <= '0;
            ledg_q   <= '0;
            hexlo_q  <= '0;
            hexhi_q  <= '0;
            lcd_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            ledr_q   <= ledr_d;
            ledg_q   <= ledg_d;
            hexlo_q  <= hexlo_d;
            hexhi_q  <= hexhi_d;
            lcd_q    <= lcd_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
        end
    end

    assign o_rdata   = rdata_q;
    assign o_rvalid  = rvalid_q;
    assign o_err     = err_q;
    assign o_io_ledr = ledr_q;
    assign o_io_ledg = ledg_q;
    assign o_io_lcd  = lcd_q;
    assign o_io_hex0 = hexlo_q[6:0];
    assign o_io_hex1 = hexlo_q[14:8];
    assign o_io_hex2 = hexlo_q[22:16];
    assign o_io_hex3 = hexlo_q[30:24];
    assign o_io_hex4 = hexhi_q[6:0];
    assign o_io_hex5 = hexhi_q[14:8];
    assign o_io_hex6 = hexhi_q[22:16];
    assign o_io_hex7 = hexhi_q[30:24];

endmodule

// File: tb/tb_io_buffer.sv
// Bench for io_buffer: stimulus pushes expected responses into a queue, a
// monitor pops and compares whenever o_rvalid or o_err is seen.
module tb_io_buffer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] addr = '0, wdata = '0, sw = '0;
    logic [3:0]  bmask = '0;
    logic        wren = 1'b0, rden = 1'b0;
    logic [31:0] rdata, ledr, ledg, lcd;
    logic        rvalid, err;
    logic [6:0]  hex [8];

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        rvalid;
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    io_buffer #(.SW_SYNC_STAGES(2)) dut (
        .i_clk(clk), .i_reset(rst_n),
        .i_addr(addr), .i_wdata(wdata), .i_bmask(bmask),
        .i_wren(wren), .i_rden(rden),
        .o_rdata(rdata), .o_rvalid(rvalid), .o_err(err),
        .i_io_sw(sw),
        .o_io_ledr(ledr), .o_io_ledg(ledg), .o_io_lcd(lcd),
        .o_io_hex0(hex[0]), .o_io_hex1(hex[1]), .o_io_hex2(hex[2]), .o_io_hex3(hex[3]),
        .o_io_hex4(hex[4]), .o_io_hex5(hex[5]), .o_io_hex6(hex[6]), .o_io_hex7(hex[7])
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endfunction

    // Response monitor, sampling on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rvalid === 1'b1 || err === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_resp: rvalid=%0b err=%0b rdata=0x%08h", rvalid, err, rdata);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("resp_rvalid", {31'd0, rvalid}, {31'd0, e.rvalid});
                    chk("resp_rdata", rdata, e.rdata);
                    chk("resp_err", {31'd0, err}, {31'd0, e.err});
                end
            end else if (rdata !== 32'd0) begin
                checks++;
                failures++;
                $display("FAIL rdata_idle: got 0x%08h expected 0x00000000", rdata);
            end
        end
    end

    // Each task is entered just after a falling edge and returns one falling edge later.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        addr = a; wdata = d; bmask = m; wren = 1'b1;
        @(negedge clk);
        wren = 1'b0; bmask = '0;
    endtask

    task automatic do_read(input logic [31:0] a, input logic [3:0] m, input exp_t e);
        addr = a; bmask = m; rden = 1'b1;
        exp_q.push_back(e);
        @(negedge clk);
        rden = 1'b0; bmask = '0;
    endtask

    task automatic do_rw(input logic [31:0] a, input logic [31:0] d, input exp_t e);
        addr = a; wdata = d; bmask = 4'hF; wren = 1'b1; rden = 1'b1;
        exp_q.push_back(e);
        @(negedge clk);
        wren = 1'b0; rden = 1'b0; bmask = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        idle(2);
        chk("reset_ledr", ledr, 32'd0);
        chk("reset_rvalid", {31'd0, rvalid}, 32'd0);
        chk("reset_err", {31'd0, err}, 32'd0);
        rst_n = 1'b1;

        // Byte store to LEDR, first edge after reset release.
        do_write(32'h1000_0000, 32'h0000_0048, 4'b0001);
        chk("ledr_byte0", ledr, 32'h0000_0048);
        do_read(32'h1000_0000, 4'b0000, '{1'b1, 32'h0000_0048, 1'b0});
        idle(1);

        // Full-word store to HEX0-3; bit 7 of each lane dropped.
        do_write(32'h1000_2000, 32'hFFFF_FFFF, 4'b1111);
        chk("hex0", {25'd0, hex[0]}, 32'h7F);
        chk("hex3", {25'd0, hex[3]}, 32'h7F);
        chk("hex4", {25'd0, hex[4]}, 32'h00);
        chk("hex7", {25'd0, hex[7]}, 32'h00);
        do_read(32'h1000_2000, 4'b0001, '{1'b1, 32'h7F7F_7F7F, 1'b0});

        // HEX4-7 partial lanes: lane3 0x85->05, lane1 0x87->07.
        do_write(32'h1000_3abc, 32'h8586_8788, 4'b1010);
        chk("hex5", {25'd0, hex[5]}, 32'h07);
        chk("hex7b", {25'd0, hex[7]}, 32'h05);
        chk("hex4b", {25'd0, hex[4]}, 32'h00);
        do_read(32'h1000_3000, 4'b1111, '{1'b1, 32'h0500_0700, 1'b0});

        // LEDG middle-lane merge.
        do_write(32'h1000_1000, 32'h1122_3344, 4'b1111);
        do_write(32'h1000_1004, 32'hAABB_CCDD, 4'b0110);
        chk("ledg_merge", ledg, 32'h11BB_CC44);

        // LCD with nonzero offset bits.
        do_write(32'h1000_4FFC, 32'hDEAD_BEEF, 4'b1111);
        chk("lcd", lcd, 32'hDEAD_BEEF);

        // Back-to-back reads, including one with low address bits set.
        do_read(32'h1000_1000, 4'b0001, '{1'b1, 32'h11BB_CC44, 1'b0});
        do_read(32'h1000_4123, 4'b0000, '{1'b1, 32'hDEAD_BEEF, 1'b0});
        do_read(32'h1000_0000, 4'b1000, '{1'b1, 32'h0000_0048, 1'b0});

        // Same-cycle read and write to LEDR returns the pre-write word.
        do_rw(32'h1000_0000, 32'h1234_5678, '{1'b1, 32'h0000_0048, 1'b0});
        chk("ledr_after_rw", ledr, 32'h1234_5678);

        // Switch synchronizer: sampled at edge 0, visible at edge 2.
        sw = 32'h0000_A5A5;
        idle(1);
        do_read(32'h1001_0000, 4'b1111, '{1'b1, 32'h0000_0000, 1'b0});
        idle(1);
        do_read(32'h1001_0000, 4'b1111, '{1'b1, 32'h0000_A5A5, 1'b0});

        // Errors: unmapped store, store to SW, unmapped load, combined load+store.
        exp_q.push_back('{1'b0, 32'h0, 1'b1});
        do_write(32'h2000_0000, 32'hFFFF_FFFF, 4'b1111);
        exp_q.push_back('{1'b0, 32'h0, 1'b1});
        do_write(32'h1001_0000, 32'hFFFF_FFFF, 4'b1111);
        chk("err_no_ledr_change", ledr, 32'h1234_5678);
        chk("err_no_lcd_change", lcd, 32'hDEAD_BEEF);
        do_read(32'h2000_0000, 4'b1111, '{1'b1, 32'h0, 1'b1});
        do_rw(32'h3000_0000, 32'h5555_5555, '{1'b1, 32'h0, 1'b1});
        idle(2);

        // Reset asserted mid-request: the pending read is dropped.
        addr = 32'h1000_0000; rden = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ledr", ledr, 32'd0);
        chk("rst_ledg", ledg, 32'd0);
        chk("rst_lcd", lcd, 32'd0);
        chk("rst_hex", {hex[0], hex[3], hex[5], hex[7], 4'd0}, 32'd0);
        chk("rst_resp", {rdata[30:0] | {30'd0, rvalid}, err}, 32'd0);
        @(negedge clk);
        rden = 1'b0;
        idle(1);
        rst_n = 1'b1;
        idle(4);
        chk("post_rst_ledr", ledr, 32'd0);
        do_write(32'h1000_0000, 32'h0000_00C3, 4'b0001);
        chk("post_rst_write", ledr, 32'h0000_00C3);

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/io_buffer.md
IO_BUFFER -- requirements
Module: io_buffer

Interface
REQ-001 SHALL have parameter SW_SYNC_STAGES, default 2, the number of flops in the switch input synchronizer (legal range 2..4).
REQ-002 SHALL have one clock and an asynchronous active-low reset: i_clk input 1, the sole clock; i_reset input 1, the asynchronous active-low reset.
REQ-003 i_addr  input  32  load/store byte address from the LSU.
REQ-004 i_wdata  input  32  store data.
REQ-005 i_bmask  input  4  byte enables; bit n enables byte lane n.
REQ-006 i_wren  input  1  store request, one cycle per request.
REQ-007 i_rden  input  1  load request, one cycle per request.
REQ-008 o_rdata  output  32  load data, valid while o_rvalid=1.
REQ-009 o_rvalid  output  1  one-cycle load-response pulse.
REQ-010 o_err  output  1  one-cycle pulse on an access to an unmapped region or a store to a read-only region.
REQ-011 i_io_sw  input  32  asynchronous board switches.
REQ-012 o_io_ledr, o_io_ledg, o_io_lcd  output  32 each  registered IO outputs.
REQ-013 o_io_hex0..o_io_hex7  output  7 each  seven-segment outputs.

Function
REQ-014 SHALL decode the region on i_addr[31:12]: 0x10000 LEDR, 0x10001 LEDG, 0x10002 HEX0-3, 0x10003 HEX4-7, 0x10004 LCD, 0x10010 SW (read-only); every other value is unmapped.
REQ-015 SHALL ignore i_addr[11:2] and i_addr[1:0] inside a region; each region is one 32-bit word.
REQ-016 On i_wren, SHALL update only the byte lanes enabled by i_bmask at the rising edge; the new value is visible on the outputs in the next cycle.
REQ-017 HEX regions SHALL map byte lane n[6:0] to HEXn (0x10002) or HEX(n+4) (0x10003); bit 7 of each lane is discarded on write and reads as 0.
REQ-018 On i_rden, SHALL register o_rdata and assert o_rvalid for exactly one cycle in the following cycle (latency 1), returning the full word regardless of i_bmask.
REQ-019 A read of SW SHALL return the synchronizer output, delayed SW_SYNC_STAGES cycles from i_io_sw.
REQ-020 i_wren and i_rden in the same cycle to the same region SHALL return the pre-write value.
REQ-021 An unmapped read SHALL return 0 with o_rvalid=1 and o_err=1 in the response cycle.
REQ-022 An unmapped write or a write to SW SHALL change no state and pulse o_err in the next cycle.
REQ-023 Simultaneous erroneous read and write SHALL produce a single o_err pulse.
REQ-024 o_rdata SHALL be 0 whenever o_rvalid=0.
REQ-025 Back-to-back requests SHALL be accepted every cycle; no stall or back-pressure exists.

Reset
REQ-026 i_reset=0 SHALL asynchronously clear all IO registers, the synchronizer flops, o_rdata, o_rvalid and o_err to 0.
REQ-027 A read issued in the cycle reset asserts SHALL be discarded, with no o_rvalid pulse after reset is released.
REQ-028 After reset is released, the first request SHALL be accepted on the first rising edge.

Structure
REQ-029 Package io_pkg SHALL hold the region base constants, a region enum (REG_LEDR, REG_LEDG, REG_HEXLO, REG_HEXHI, REG_LCD, REG_SW, REG_NONE) and a function that applies a byte mask.
REQ-030 Sub-module sw_sync SHALL implement the parameterised N-flop synchronizer; all other logic is inline.

Verification
REQ-031 Store 0x00000048 to 0x10000000 with i_bmask=0001 -> o_io_ledr=0x00000048 in the next cycle; read back gives o_rdata=0x48 and o_rvalid for one cycle.
REQ-032 Store 0xFFFFFFFF to 0x10002000 with i_bmask=1111 -> hex0..hex3=7'h7F; read returns 0x7F7F7F7F; hex4..hex7 remain 0.
REQ-033 With LEDG=0x11223344, store 0xAABBCCDD with i_bmask=0110 -> o_io_ledg=0x11BBCC44.
REQ-034 Set i_io_sw=0x0000A5A5, read SW at cycle 1 and again at cycle 3 (SW_SYNC_STAGES=2) -> 0 then 0x0000A5A5.
REQ-035 Store to 0x20000000 and store to 0x10010000 -> no state change, one o_err pulse each; read of 0x20000000 -> o_rdata=0, o_rvalid=1, o_err=1.
REQ-036 Assert i_rden, then pull i_reset low before the next edge -> o_rvalid never pulses; all outputs are 0 during reset.
